// File: rtl/store_merge_unit.sv
// store_merge_unit
// Memory-access front end between the EX/MEM register and a word-only data
// memory. Loads and word stores pass straight through. Byte and halfword
// stores become a read-modify-write pair:
//   - IDLE: the containing word is read while the pipeline is stalled.
//   - RMW_WRITE: the merged word is written back.
// Optional feature macro: STORE_MISALIGN_TRAP_EN.
//   - Defined: misaligned sw/sh raise misalign_out and issue no memory access.
//   - Undefined: sw is word-aligned by force, sh picks its lane from
//     addr_in[1], and misalign_out is tied low.
module store_merge_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32   // lane merge assumes 32; do not override
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] storedata_in,
    input  logic              load_in,
    input  logic              sw_in,
    input  logic              sh_in,
    input  logic              sb_in,
    input  logic [DATA_W-1:0] mem_readdata_in,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_writedata_out,
    output logic              mem_re_out,
    output logic              mem_we_out,
    output logic [1:0]        mem_size_out,
    output logic              stall_out,
    output logic              misalign_out
);

    typedef enum logic {
        IDLE      = 1'b0,
        RMW_WRITE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   merge_q, merge_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    // Decoded, prioritised request (sw > sh > sb > load)
    logic                do_sw, do_sh, do_sb, do_ld;
    logic                mis_sw, mis_sh;
    logic [ADDR_W-1:0]   word_addr;
    logic [ADDR_W-1:0]   sw_addr;

    // Raw combinational outputs before reset gating
    logic                re_c, we_c, stall_c, misalign_c;
    logic [ADDR_W-1:0]   addr_c;
    logic [DATA_W-1:0]   wdata_c;

    // Read word with the store lane substituted
    logic [3:0]          lane_hit;
    logic [DATA_W-1:0]   merged_word;

    // Priority decode of the request lines and aligned word address
    always_comb begin
        do_sw     = sw_in;
        do_sh     = !sw_in && sh_in;
        do_sb     = !sw_in && !sh_in && sb_in;
        do_ld     = !sw_in && !sh_in && !sb_in && load_in;
        word_addr = {addr_in[ADDR_W-1:2], 2'b00};
`ifdef STORE_MISALIGN_TRAP_EN
        mis_sw    = do_sw && (addr_in[1:0] != 2'b00);
        mis_sh    = do_sh && addr_in[0];
        sw_addr   = addr_in;
`else
        mis_sw    = 1'b0;
        mis_sh    = 1'b0;
        sw_addr   = word_addr;
`endif
    end

    // Per-byte lane merge: a halfword covers two lanes chosen by addr_in[1],
    // a byte covers one lane chosen by addr_in[1:0].
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_hit[gi] = do_sh ? (addr_in[1] == 1'(gi / 2))
                                        : (addr_in[1:0] == 2'(gi));
            assign merged_word[8*gi +: 8] =
                !lane_hit[gi] ? mem_readdata_in[8*gi +: 8] :
                do_sh         ? storedata_in[8*(gi % 2) +: 8] :
                                storedata_in[7:0];
        end
    endgenerate

    // Next-state and memory-side outputs for both states
    always_comb begin
        state_d    = state_q;
        merge_d    = merge_q;
        addr_d     = addr_q;
        re_c       = 1'b0;
        we_c       = 1'b0;
        stall_c    = 1'b0;
        misalign_c = 1'b0;
        addr_c     = addr_in;
        wdata_c    = storedata_in;

        case (state_q)
            IDLE: begin
                if (mis_sw || mis_sh) begin
                    // Trapped store: flag only, memory untouched
                    misalign_c = 1'b1;
                end else if (do_sw) begin
                    we_c   = 1'b1;
                    addr_c = sw_addr;
                end else if (do_sh || do_sb) begin
                    re_c    = 1'b1;
                    addr_c  = word_addr;
                    stall_c = 1'b1;
                    merge_d = merged_word;
                    addr_d  = word_addr;
                    state_d = RMW_WRITE;
                end else if (do_ld) begin
                    re_c = 1'b1;
                end
            end
            RMW_WRITE: begin
                // Request inputs still hold the same store; ignore them
                we_c    = 1'b1;
                addr_c  = addr_q;
                wdata_c = merge_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and merge registers; reset aborts any pending write-back
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            merge_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
            addr_q  <= addr_d;
        end
    end

    // Control outputs are forced quiet while reset is held low
    assign mem_re_out        = reset & re_c;
    assign mem_we_out        = reset & we_c;
    assign stall_out         = reset & stall_c;
    assign misalign_out      = reset & misalign_c;
    assign mem_addr_out      = addr_c;
    assign mem_writedata_out = wdata_c;
    assign mem_size_out      = 2'b11;

endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit.
// Stimulus pushes the expected memory transactions (read / write / misalign)
// into a queue; a negedge monitor pops one entry per observed access.
// A small word memory answers the DUT's combinational reads.
module tb_store_merge_unit;

    localparam int K_RD  = 0;
    localparam int K_WR  = 1;
    localparam int K_MIS = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic        stall;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr_in = '0;
    logic [31:0] storedata_in = '0;
    logic        load_in = 1'b0, sw_in = 1'b0, sh_in = 1'b0, sb_in = 1'b0;
    logic [31:0] mem_readdata_in;
    logic [31:0] mem_addr_out, mem_writedata_out;
    logic        mem_re_out, mem_we_out, stall_out, misalign_out;
    logic [1:0]  mem_size_out;

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [logic [31:0]];   // reference memory, full word address
    logic [31:0] tb_mem [0:63];            // memory seen by the DUT
    logic        pl_en = 1'b0;
    logic [31:0] pl_addr = '0, pl_data = '0;

    always #5 clock = ~clock;

    store_merge_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock             (clock),
        .reset             (reset),
        .addr_in           (addr_in),
        .storedata_in      (storedata_in),
        .load_in           (load_in),
        .sw_in             (sw_in),
        .sh_in             (sh_in),
        .sb_in             (sb_in),
        .mem_readdata_in   (mem_readdata_in),
        .mem_addr_out      (mem_addr_out),
        .mem_writedata_out (mem_writedata_out),
        .mem_re_out        (mem_re_out),
        .mem_we_out        (mem_we_out),
        .mem_size_out      (mem_size_out),
        .stall_out         (stall_out),
        .misalign_out      (misalign_out)
    );

    assign mem_readdata_in = tb_mem[mem_addr_out[7:2]];

    always @(posedge clock) begin
        if (pl_en)
            tb_mem[pl_addr[7:2]] <= pl_data;
        else if (mem_we_out)
            tb_mem[mem_addr_out[7:2]] <= mem_writedata_out;
    end

    // Monitor: every observed access must match the head of the queue
    always @(negedge clock) begin : mon
        exp_t e;
        int   ka;
        logic ok;
        if (mem_re_out && mem_we_out) begin
            n_cmp++;
            n_bad++;
            $display("FAIL re_we_overlap: re=%0b we=%0b required not both high", mem_re_out, mem_we_out);
        end
        if (mem_re_out || mem_we_out || misalign_out) begin
            ka = misalign_out ? K_MIS : (mem_we_out ? K_WR : K_RD);
            n_cmp++;
            n_txn++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_access: kind=%0d addr=%h data=%h required no access", ka, mem_addr_out, mem_writedata_out);
            end else begin
                e  = exp_q.pop_front();
                ok = (ka == e.kind) && (stall_out == e.stall) && (mem_size_out == 2'b11);
                if (e.kind != K_MIS && mem_addr_out != e.addr) ok = 1'b0;
                if (e.kind == K_WR && mem_writedata_out != e.data) ok = 1'b0;
                if (!ok) begin
                    n_bad++;
                    $display("FAIL access: got kind=%0d addr=%h data=%h stall=%0b size=%0d required kind=%0d addr=%h data=%h stall=%0b size=3",
                             ka, mem_addr_out, mem_writedata_out, stall_out, mem_size_out, e.kind, e.addr, e.data, e.stall);
                end else begin
                    $display("txn %0d kind=%0d addr=%h data=%h stall=%0b ok", n_txn, ka, mem_addr_out, mem_writedata_out, stall_out);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    task automatic exp_push(input int kind, input logic [31:0] a, input logic [31:0] d, input logic st);
        exp_t e;
        e.kind = kind; e.addr = a; e.data = d; e.stall = st;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] wa);
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return 32'h0;
    endfunction

    // Reference model: memory traffic that one pipeline instruction should cause
    task automatic model_push(input logic ld, input logic sw, input logic sh, input logic sb,
                              input logic [31:0] a, input logic [31:0] d);
        logic [31:0] wa, old, nw, mask;
        int          shamt;
        wa = {a[31:2], 2'b00};
        if (sw) begin
`ifdef STORE_MISALIGN_TRAP_EN
            if (a[1:0] != 2'b00) begin
                exp_push(K_MIS, a, 32'h0, 1'b0);
                return;
            end
`endif
            exp_push(K_WR, wa, d, 1'b0);
            ref_mem[wa] = d;
        end else if (sh || sb) begin
`ifdef STORE_MISALIGN_TRAP_EN
            if (sh && a[0]) begin
                exp_push(K_MIS, a, 32'h0, 1'b0);
                return;
            end
`endif
            old   = ref_rd(wa);
            shamt = sh ? 16 * int'(a[1]) : 8 * int'(a[1:0]);
            mask  = sh ? 32'h0000_FFFF : 32'h0000_00FF;
            nw    = (old & ~(mask << shamt)) | ((d & mask) << shamt);
            exp_push(K_RD, wa, 32'h0, 1'b1);
            exp_push(K_WR, wa, nw, 1'b0);
            ref_mem[wa] = nw;
        end else if (ld) begin
            exp_push(K_RD, a, 32'h0, 1'b0);
        end
    endtask

    // Present one instruction and hold it until the pipeline may advance
    task automatic apply(input logic ld, input logic sw, input logic sh, input logic sb,
                         input logic [31:0] a, input logic [31:0] d);
        int n;
        @(posedge clock); #1;
        load_in = ld; sw_in = sw; sh_in = sh; sb_in = sb;
        addr_in = a; storedata_in = d;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (stall_out && n < 6);
        if (stall_out) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stall_timeout: stall_out=%0b after %0d cycles required 0", stall_out, n);
        end
    endtask

    task automatic drive(input logic ld, input logic sw, input logic sh, input logic sb,
                         input logic [31:0] a, input logic [31:0] d);
        model_push(ld, sw, sh, sb, a, d);
        apply(ld, sw, sh, sb, a, d);
    endtask

    task automatic idle();
        @(posedge clock); #1;
        load_in = 0; sw_in = 0; sh_in = 0; sb_in = 0;
    endtask

    // Write a word into both the DUT-side memory and the reference memory
    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        idle();
        pl_en = 1'b1; pl_addr = a; pl_data = v;
        @(posedge clock); #1;
        pl_en = 1'b0;
        ref_mem[{a[31:2], 2'b00}] = v;
    endtask

    initial begin
        logic ld, sw, sh, sb;
        int   p;

        // Reset state with a live request on the inputs
        sw_in = 1'b1; sb_in = 1'b1; addr_in = 32'h1000_0003; storedata_in = 32'h5555_AAAA;
        @(negedge clock);
        chk("rst_stall", {31'h0, stall_out}, 32'h0);
        chk("rst_misalign", {31'h0, misalign_out}, 32'h0);
        chk("rst_re", {31'h0, mem_re_out}, 32'h0);
        chk("rst_we", {31'h0, mem_we_out}, 32'h0);
        chk("rst_size", {30'h0, mem_size_out}, 32'h3);
        sw_in = 1'b0; sb_in = 1'b0;
        reset = 1'b1;

        // Reset asserted while in RMW_WRITE: the write-back must not happen
        exp_push(K_RD, 32'h1000_0000, 32'h0, 1'b1);
        @(posedge clock); #1;
        sb_in = 1'b1; addr_in = 32'h1000_0002; storedata_in = 32'h0000_00AA;
        @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("midrmw_we", {31'h0, mem_we_out}, 32'h0);
        chk("midrmw_stall", {31'h0, stall_out}, 32'h0);
        @(negedge clock);
        sb_in = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_we", {31'h0, mem_we_out}, 32'h0);
        exp_push(K_WR, 32'h1000_0000, 32'h0BAD_CAFE, 1'b0);
        apply(0, 1, 0, 0, 32'h1000_0000, 32'h0BAD_CAFE);

        // Randomised traffic inside a 256-byte window
        for (int i = 0; i < 64; i++) preload(32'h1000_0000 + 32'(i * 4), $urandom);
        for (int i = 0; i < 300; i++) begin
            p  = int'($urandom_range(0, 4));
            ld = (p == 1); sw = (p == 2); sh = (p == 3); sb = (p == 4);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: ld = 1'b1;
                    1: sw = 1'b1;
                    2: sh = 1'b1;
                    default: sb = 1'b1;
                endcase
            end
            drive(ld, sw, sh, sb, 32'h1000_0000 | 32'($urandom_range(0, 255)), $urandom);
        end

        // sb 0xAA into lane 2 of 0x11223344
        preload(32'h1000_0000, 32'h1122_3344);
        exp_push(K_RD, 32'h1000_0000, 32'h0, 1'b1);
        exp_push(K_WR, 32'h1000_0000, 32'h11AA_3344, 1'b0);
        apply(0, 0, 0, 1, 32'h1000_0002, 32'h0000_00AA);

        // Back-to-back halfword stores at the top of the address space
        preload(32'h7FFF_F004, 32'hDEAD_BEEF);
        exp_push(K_RD, 32'h7FFF_F004, 32'h0, 1'b1);
        exp_push(K_WR, 32'h7FFF_F004, 32'h1234_BEEF, 1'b0);
        exp_push(K_RD, 32'h7FFF_F004, 32'h0, 1'b1);
        exp_push(K_WR, 32'h7FFF_F004, 32'h1234_5678, 1'b0);
        apply(0, 0, 1, 0, 32'h7FFF_F006, 32'h0000_1234);
        apply(0, 0, 1, 0, 32'h7FFF_F004, 32'h0000_5678);

        // sw wins over a simultaneous sb and does not stall
        exp_push(K_WR, 32'h1004_0008, 32'hCAFE_F00D, 1'b0);
        apply(0, 1, 0, 1, 32'h1004_0008, 32'hCAFE_F00D);

        // Load directly after an RMW write-back
        preload(32'h1000_0000, 32'h1122_3344);
        exp_push(K_RD, 32'h1000_0000, 32'h0, 1'b1);
        exp_push(K_WR, 32'h1000_0000, 32'h1122_7744, 1'b0);
        exp_push(K_RD, 32'h1000_0004, 32'h0, 1'b0);
        apply(0, 0, 0, 1, 32'h1000_0001, 32'h0000_0077);
        apply(1, 0, 0, 0, 32'h1000_0004, 32'h0);

        // Halfword store to an odd address
        preload(32'h1000_0000, 32'h1122_3344);
`ifdef STORE_MISALIGN_TRAP_EN
        exp_push(K_MIS, 32'h1000_0001, 32'h0, 1'b0);
        apply(0, 0, 1, 0, 32'h1000_0001, 32'h0000_BEEF);
        idle();
        @(negedge clock);
        chk("misalign_mem_unchanged", tb_mem[0], 32'h1122_3344);
`else
        exp_push(K_RD, 32'h1000_0000, 32'h0, 1'b1);
        exp_push(K_WR, 32'h1000_0000, 32'h1122_BEEF, 1'b0);
        apply(0, 0, 1, 0, 32'h1000_0001, 32'h0000_BEEF);
        idle();
        @(negedge clock);
        chk("odd_sh_lane0_mem", tb_mem[0], 32'h1122_BEEF);
`endif

        repeat (3) @(negedge clock);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Memory-access front end between the EX/MEM pipeline register and `data_memory`. It turns byte and halfword stores into word-sized read-modify-write sequences, because the memory only accepts 4-byte accesses. It passes loads and word stores through with zero added latency. While a read-modify-write is in progress it stalls the pipeline.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; fixed at 32 and must not be overridden.

Ports:
- `clock`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `addr_in`  input  32  byte address from EX/MEM.
- `storedata_in`  input  32  store source register value.
- `load_in`  input  1  load request, any size.
- `sw_in`  input  1  word store request.
- `sh_in`  input  1  halfword store request.
- `sb_in`  input  1  byte store request.
- `mem_readdata_in`  input  32  `readdata_out` from `data_memory` (combinational read).
- `mem_addr_out`  output  32  address to `data_memory`.
- `mem_writedata_out`  output  32  write word to `data_memory`.
- `mem_re_out`  output  1  read enable.
- `mem_we_out`  output  1  write enable.
- `mem_size_out`  output  2  access size; constant 2'b11.
- `stall_out`  output  1  pipeline hold; EX/MEM and earlier stages freeze while high.
- `misalign_out`  output  1  one-cycle misaligned-store flag.

## Operation
- States: IDLE, RMW_WRITE.
- Request priority: `sw_in` > `sh_in` > `sb_in` > `load_in`. Simultaneous store and load: the store wins and the load is ignored.

IDLE behaviour:
- Load: `mem_re_out`=1, `mem_addr_out`=`addr_in`, `stall_out`=0. Sub-word extraction stays in `data_memory`.
- `sw_in`: `mem_we_out`=1, `mem_addr_out`=`addr_in`, `mem_writedata_out`=`storedata_in`, `stall_out`=0. Stays in IDLE.
- `sh_in`/`sb_in`:
  - `mem_re_out`=1, `mem_addr_out`={`addr_in`[31:2],2'b00}, `stall_out`=1.
  - At the clock edge, register `merge_q` and `addr_q`, then go to RMW_WRITE.
  - `merge_q` is `mem_readdata_in` with one lane replaced:
    - sb: bits [8k+7:8k] = `storedata_in`[7:0], where k=`addr_in`[1:0].
    - sh: bits [16h+15:16h] = `storedata_in`[15:0], where h=`addr_in`[1].

RMW_WRITE behaviour:
- `mem_we_out`=1, `mem_addr_out`=`addr_q`, `mem_writedata_out`=`merge_q`, `stall_out`=0.
- Request inputs are ignored; they still hold the same instruction.
- Always returns to IDLE on the next edge.

Other outputs:
- No request: `mem_re_out`=`mem_we_out`=0, `mem_addr_out`=`addr_in`, `mem_writedata_out`=`storedata_in`.
- `mem_re_out` and `mem_we_out` are never high in the same cycle.

Reset:
- Asserting `reset` in either state forces IDLE and clears `merge_q`/`addr_q` to 0.
- A read-modify-write interrupted in RMW_WRITE issues no write after reset.
- Outputs under reset: `stall_out`=0, `misalign_out`=0, `mem_re_out`=0, `mem_we_out`=0, `mem_size_out`=2'b11.

## Timing
- Load and word-store latency: 0 extra cycles (combinational path from inputs to `mem_*`).
- Byte/halfword store: 2 cycles.
  - Cycle 1 (IDLE): read, `stall_out`=1.
  - Cycle 2 (RMW_WRITE): write, `stall_out`=0.
  - The pipeline advances at the end of cycle 2.
- Back-to-back sub-word stores: 2 cycles each, no bubble between them.
- A load or word store directly after RMW_WRITE is served in the following IDLE cycle.
- `merge_q` captures `mem_readdata_in` on the same edge that leaves IDLE.
- `misalign_out` is combinational and valid in the IDLE cycle of the offending request.

## Configuration
- `STORE_MISALIGN_TRAP_EN` defined:
  - Misaligned stores are sw with `addr_in`[1:0]≠0, or sh with `addr_in`[0]=1.
  - For these, `misalign_out`=1 for the one cycle and no read or write is issued.
  - `stall_out`=0 and the state stays IDLE.
- Not defined:
  - `misalign_out` is tied to 0.
  - sw addresses are forced to `addr_in`[1:0]=00.
  - sh lane selection uses `addr_in`[1] only, with `addr_in`[0] ignored.

## Test plan
- Reset low mid-RMW (state RMW_WRITE): next cycle `mem_we_out`=0, `stall_out`=0. After release, a sw to 0x10000000 writes in 0 cycles.
- Word 0x11223344 at 0x10000000; sb 0xAA to 0x10000002:
  - Cycle 1: `mem_re_out`=1, `stall_out`=1, `mem_addr_out`=0x10000000.
  - Cycle 2: `mem_we_out`=1, `mem_writedata_out`=0x11AA3344.
- Word 0xDEADBEEF at 0x7FFFF004; sh 0x1234 to 0x7FFFF006: write word 0x1234BEEF. Then sh 0x5678 to 0x7FFFF004 back-to-back: write 0x12345678, no idle cycle between.
- sw 0xCAFEF00D to 0x10040008 with `sb_in` also high: single-cycle write of 0xCAFEF00D, `stall_out` stays 0.
- `load_in` to 0x10000004 in the cycle after RMW_WRITE: `mem_re_out`=1, `mem_we_out`=0, address 0x10000004.
- With `STORE_MISALIGN_TRAP_EN`, sh to 0x10000001: `misalign_out`=1 for 1 cycle, `mem_we_out`=`mem_re_out`=0, memory unchanged. Without it: the write lands in lane 0.
